// File: rtl/pulse_sequencer.sv
// rtl/pulse_sequencer.sv - burst pulse sequencer with comparator mismatch counting (optional macro PULSE_SEQ_ABORT_EN adds abort_i)
module pulse_sequencer #(
  parameter int NPULSE_W = 12,
  parameter int ERRCNT_W = 16,
  parameter int GAP_CYC  = 4
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                fire_pulse_i,
  input  logic [NPULSE_W-1:0] num_pulses_i,
  input  logic [3:0]          pulse_width_i,
  input  logic [3:0]          bx_delay_i,
  input  logic                compout_expect_i,
  input  logic                compout_in_i,
  input  logic                pulser_ready_i,
  input  logic                errcnt_rst_i,
`ifdef PULSE_SEQ_ABORT_EN
  input  logic                abort_i,
`endif
  output logic                pulse_out_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                compout_last_o,
  output logic [NPULSE_W-1:0] pulse_cnt_o,
  output logic [ERRCNT_W-1:0] compout_errcnt_o
);

  // Phase counter must cover the 4-bit width/delay fields and the gap length.
  localparam int CYC_W = (GAP_CYC > 16) ? $clog2(GAP_CYC) : 4;
  localparam logic [CYC_W-1:0] GAP_LAST = (GAP_CYC > 0) ? CYC_W'(GAP_CYC - 1) : '0;
  localparam bit GAP_SKIP = (GAP_CYC == 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_PULSE,
    ST_DELAY,
    ST_SAMPLE,
    ST_GAP,
    ST_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CYC_W-1:0]      cyc_q, cyc_d;
  logic                  fire_q;
  logic [NPULSE_W-1:0]   num_q, num_d;
  logic [3:0]            width_q, width_d;
  logic [3:0]            delay_q, delay_d;
  logic                  expect_q, expect_d;
  logic [NPULSE_W-1:0]   pulse_cnt_q, pulse_cnt_d;
  logic                  last_q, last_d;
  logic [ERRCNT_W-1:0]   errcnt_q, errcnt_d;
  logic                  sample_hit;
  logic                  abort_hit;
  logic [NPULSE_W-1:0]   pulse_cnt_inc;

  assign pulse_cnt_inc = pulse_cnt_q + NPULSE_W'(1);

  // Next-state, config latch and counter updates; defaults hold every register.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    num_d       = num_q;
    width_d     = width_q;
    delay_d     = delay_q;
    expect_d    = expect_q;
    pulse_cnt_d = pulse_cnt_q;
    last_d      = last_q;
    errcnt_d    = errcnt_q;
    sample_hit  = 1'b0;
    abort_hit   = 1'b0;
`ifdef PULSE_SEQ_ABORT_EN
    abort_hit   = abort_i && (state_q != ST_IDLE);
`endif

    case (state_q)
      ST_IDLE: begin
        // Only a rising edge seen while idle starts a burst; held levels and busy-time edges are dropped.
        if (fire_pulse_i && !fire_q) begin
          num_d       = num_pulses_i;
          width_d     = pulse_width_i;
          delay_d     = bx_delay_i;
          expect_d    = compout_expect_i;
          pulse_cnt_d = '0;
          cyc_d       = '0;
          state_d     = (num_pulses_i == '0) ? ST_DONE : ST_WAIT_RDY;
        end
      end
      ST_WAIT_RDY: begin
        if (pulser_ready_i) begin
          cyc_d   = '0;
          state_d = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (cyc_q == CYC_W'(width_q)) begin
          cyc_d   = '0;
          state_d = (delay_q == 4'd0) ? ST_SAMPLE : ST_DELAY;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_DELAY: begin
        if (cyc_q == CYC_W'(delay_q - 4'd1)) begin
          cyc_d   = '0;
          state_d = ST_SAMPLE;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_SAMPLE: begin
        sample_hit  = 1'b1;
        pulse_cnt_d = pulse_cnt_inc;
        last_d      = compout_in_i;
        cyc_d       = '0;
        if (pulse_cnt_inc == num_q) begin
          state_d = ST_DONE;
        end else if (GAP_SKIP) begin
          state_d = ST_WAIT_RDY;
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cyc_q == GAP_LAST) begin
          cyc_d   = '0;
          state_d = ST_WAIT_RDY;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Clear beats a same-cycle mismatch; the count sticks at all-ones instead of wrapping.
    if (errcnt_rst_i) begin
      errcnt_d = '0;
    end else if (sample_hit && !abort_hit && (compout_in_i != expect_q) && (errcnt_q != '1)) begin
      errcnt_d = errcnt_q + ERRCNT_W'(1);
    end

    // An abort drops straight to idle and freezes the burst results where they were.
    if (abort_hit) begin
      state_d     = ST_IDLE;
      cyc_d       = '0;
      pulse_cnt_d = pulse_cnt_q;
      last_d      = last_q;
    end
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      cyc_q       <= '0;
      fire_q      <= 1'b0;
      num_q       <= '0;
      width_q     <= '0;
      delay_q     <= '0;
      expect_q    <= 1'b0;
      pulse_cnt_q <= '0;
      last_q      <= 1'b0;
      errcnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      fire_q      <= fire_pulse_i;
      num_q       <= num_d;
      width_q     <= width_d;
      delay_q     <= delay_d;
      expect_q    <= expect_d;
      pulse_cnt_q <= pulse_cnt_d;
      last_q      <= last_d;
      errcnt_q    <= errcnt_d;
    end
  end

  assign pulse_out_o      = (state_q == ST_PULSE);
  assign busy_o           = (state_q != ST_IDLE);
  assign done_o           = (state_q == ST_DONE);
  assign compout_last_o   = last_q;
  assign pulse_cnt_o      = pulse_cnt_q;
  assign compout_errcnt_o = errcnt_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// tb/tb_pulse_sequencer.sv - self-checking bench for pulse_sequencer
module tb_pulse_sequencer;

  localparam int GAP  = 4;
  localparam int MAXC = 512;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fire = 1'b0;
  logic [11:0] num = '0;
  logic [3:0]  width = '0;
  logic [3:0]  delay = '0;
  logic        expct = 1'b0;
  logic        comp = 1'b0;
  logic        rdy = 1'b0;
  logic        erst = 1'b0;
  logic        pulse, busy, done, last;
  logic [11:0] pcnt;
  logic [15:0] ecnt;

  logic        s_fire = 1'b0;
  logic [3:0]  s_num = '0;
  logic [3:0]  s_width = '0;
  logic [3:0]  s_delay = '0;
  logic        s_expct = 1'b0;
  logic        s_comp = 1'b0;
  logic        s_rdy = 1'b0;
  logic        s_erst = 1'b0;
  logic        s_pulse, s_busy, s_done, s_last;
  logic [3:0]  s_pcnt;
  logic [3:0]  s_ecnt;
`ifdef PULSE_SEQ_ABORT_EN
  logic        abort = 1'b0;
  logic        s_abort = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  pulse_sequencer #(.NPULSE_W(12), .ERRCNT_W(16), .GAP_CYC(GAP)) dut (
    .clock_i(clk), .reset_i(reset), .fire_pulse_i(fire), .num_pulses_i(num),
    .pulse_width_i(width), .bx_delay_i(delay), .compout_expect_i(expct),
    .compout_in_i(comp), .pulser_ready_i(rdy), .errcnt_rst_i(erst),
`ifdef PULSE_SEQ_ABORT_EN
    .abort_i(abort),
`endif
    .pulse_out_o(pulse), .busy_o(busy), .done_o(done), .compout_last_o(last),
    .pulse_cnt_o(pcnt), .compout_errcnt_o(ecnt)
  );

  pulse_sequencer #(.NPULSE_W(4), .ERRCNT_W(4), .GAP_CYC(0)) dut_sat (
    .clock_i(clk), .reset_i(reset), .fire_pulse_i(s_fire), .num_pulses_i(s_num),
    .pulse_width_i(s_width), .bx_delay_i(s_delay), .compout_expect_i(s_expct),
    .compout_in_i(s_comp), .pulser_ready_i(s_rdy), .errcnt_rst_i(s_erst),
`ifdef PULSE_SEQ_ABORT_EN
    .abort_i(s_abort),
`endif
    .pulse_out_o(s_pulse), .busy_o(s_busy), .done_o(s_done), .compout_last_o(s_last),
    .pulse_cnt_o(s_pcnt), .compout_errcnt_o(s_ecnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n; int w; int d; bit ex; bit cmp;
    int done_c; int cnt; int err; bit last;
  } row_t;

  row_t rows[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Directed burst with ready=1 and a constant comparator level; config scrambled after start.
  task automatic run_row(input row_t r);
    int pulses, done_n, done_at, run;
    fire = 1'b1; num = 12'(r.n); width = 4'(r.w); delay = 4'(r.d);
    expct = r.ex; comp = r.cmp; rdy = 1'b1; erst = 1'b0;
    @(negedge clk);
    pulses = 0; done_n = 0; done_at = -1; run = 0;
    for (int c = 1; c <= r.done_c + 1; c++) begin
      chk("row_busy", 32'(busy), 32'(c <= r.done_c));
      if (pulse) begin
        if (run == 0) pulses++;
        run++;
      end else if (run != 0) begin
        chk("row_pulse_len", 32'(run), 32'(r.w + 1));
        run = 0;
      end
      if (done) begin
        done_n++;
        done_at = c;
      end
      fire = 1'b0; num = 12'($urandom); width = 4'($urandom);
      delay = 4'($urandom); expct = 1'($urandom);
      @(negedge clk);
    end
    chk("row_pulses", 32'(pulses), 32'(r.n));
    chk("row_done_count", 32'(done_n), 32'd1);
    chk("row_done_cycle", 32'(done_at), 32'(r.done_c));
    chk("row_pulse_cnt", 32'(pcnt), 32'(r.cnt));
    chk("row_errcnt", 32'(ecnt), 32'(r.err));
    chk("row_last", 32'(last), 32'(r.last));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, done_n;
    int m_cnt, m_err;
    bit m_last;
    bit rdy_t[MAXC];
    bit cmp_t[MAXC];
    bit ep[MAXC];
    bit es[MAXC];

    rows[0] = '{3, 2, 1, 1'b1, 1'b1, 27, 3, 0, 1'b1};
    rows[1] = '{5, 0, 0, 1'b1, 1'b0, 32, 5, 5, 1'b0};
    rows[2] = '{0, 0, 0, 1'b1, 1'b1, 1, 0, 5, 1'b0};
    rows[3] = '{1, 15, 15, 1'b0, 1'b1, 34, 1, 6, 1'b1};
    rows[4] = '{2, 0, 15, 1'b0, 1'b0, 41, 2, 6, 1'b0};
    rows[5] = '{4, 7, 0, 1'b1, 1'b1, 53, 4, 6, 1'b1};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_pulse", 32'(pulse), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_last", 32'(last), 0);
    chk("rst_pulse_cnt", 32'(pcnt), 0);
    chk("rst_errcnt", 32'(ecnt), 0);

    foreach (rows[i]) begin
      run_row(rows[i]);
      repeat (2) @(negedge clk);
    end

    // Ready held low for ten cycles after start.
    fire = 1'b1; num = 12'd1; width = 4'd0; delay = 4'd0; expct = 1'b1; comp = 1'b1; rdy = 1'b0;
    @(negedge clk);
    for (int c = 1; c <= 10; c++) begin
      chk("rdy_wait_busy", 32'(busy), 1);
      chk("rdy_wait_pulse", 32'(pulse), 0);
      fire = 1'b0;
      @(negedge clk);
    end
    chk("rdy_rise_pulse_low", 32'(pulse), 0);
    rdy = 1'b1;
    @(negedge clk);
    chk("rdy_pulse_next", 32'(pulse), 1);
    @(negedge clk);
    chk("rdy_pulse_fall", 32'(pulse), 0);
    @(negedge clk);
    chk("rdy_done", 32'(done), 1);
    @(negedge clk);
    chk("rdy_idle", 32'(busy), 0);
    chk("rdy_pulse_cnt", 32'(pcnt), 1);
    repeat (2) @(negedge clk);

    // errcnt_rst in the same cycle as a mismatching sample.
    fire = 1'b1; num = 12'd1; width = 4'd0; delay = 4'd0; expct = 1'b1; comp = 1'b0; rdy = 1'b1;
    @(negedge clk);
    fire = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("clr_before", 32'(ecnt), 6);
    erst = 1'b1;
    @(negedge clk);
    erst = 1'b0;
    chk("clr_priority", 32'(ecnt), 0);
    chk("clr_pulse_cnt", 32'(pcnt), 1);
    chk("clr_done", 32'(done), 1);
    repeat (2) @(negedge clk);

    // Zero-pulse burst with fire held high afterwards.
    fire = 1'b1; num = 12'd0;
    @(negedge clk);
    chk("zero_done", 32'(done), 1);
    chk("zero_busy", 32'(busy), 1);
    chk("zero_pulse", 32'(pulse), 0);
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      chk("zero_no_restart", 32'(busy), 0);
    end
    fire = 1'b0;
    @(negedge clk);

    // Second fire edge while busy is dropped.
    fire = 1'b1; num = 12'd2; width = 4'd1; delay = 4'd1; expct = 1'b1; comp = 1'b0; rdy = 1'b1;
    @(negedge clk);
    pulses = 0; done_n = 0;
    for (int c = 1; c <= 18; c++) begin
      if (pulse && c > 1) pulses += 0;
      if (done) done_n++;
      fire = (c >= 2);
      @(negedge clk);
      if (pulse && !dut.pulse_out_o) pulses += 0;
    end
    chk("edge_busy_ignored", 32'(busy), 0);
    chk("edge_done_count", 32'(done_n), 1);
    chk("edge_pulse_cnt", 32'(pcnt), 2);
    chk("edge_errcnt", 32'(ecnt), 2);
    fire = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a pulse.
    fire = 1'b1; num = 12'd2; width = 4'd7; delay = 4'd0; expct = 1'b1; comp = 1'b1; rdy = 1'b1;
    @(negedge clk);
    fire = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_pulse_high", 32'(pulse), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_pulse", 32'(pulse), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_errcnt", 32'(ecnt), 0);
    chk("mid_rst_last", 32'(last), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mid_rst_no_done", 32'(done), 0);
    end

`ifdef PULSE_SEQ_ABORT_EN
    // Abort during the delay phase.
    fire = 1'b1; num = 12'd2; width = 4'd1; delay = 4'd3; rdy = 1'b1;
    @(negedge clk);
    fire = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_in_delay", 32'(busy && !pulse), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_pulse", 32'(pulse), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_pulse_cnt", 32'(pcnt), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 0);
    end
`endif

    // Randomized bursts against a timeline model.
    m_cnt = 0; m_err = 0; m_last = 1'b0;
    for (int b = 0; b < 25; b++) begin
      int n, w, d, t, tp, s, done_c;
      bit ex;
      n = $urandom_range(0, 6); w = $urandom_range(0, 15); d = $urandom_range(0, 15);
      ex = 1'($urandom);
      for (int i = 0; i < MAXC; i++) begin
        rdy_t[i] = (i % 8 == 0) || ($urandom % 4 != 0);
        cmp_t[i] = 1'($urandom);
        ep[i] = 1'b0;
        es[i] = 1'b0;
      end
      t = 1; s = 0;
      for (int k = 0; k < n; k++) begin
        tp = t;
        while (!rdy_t[tp] && tp < MAXC - 1) tp++;
        for (int i = tp + 1; i <= tp + 1 + w; i++) ep[i] = 1'b1;
        s = tp + 2 + w + d;
        es[s] = 1'b1;
        t = s + 1 + GAP;
      end
      done_c = (n == 0) ? 1 : s + 1;
      for (int c = 0; c <= done_c + 1; c++) begin
        chk("rnd_pulse", 32'(pulse), 32'(ep[c]));
        chk("rnd_busy", 32'(busy), 32'(c >= 1 && c <= done_c));
        chk("rnd_done", 32'(done), 32'(c == done_c));
        chk("rnd_pulse_cnt", 32'(pcnt), 32'(m_cnt));
        chk("rnd_errcnt", 32'(ecnt), 32'(m_err));
        chk("rnd_last", 32'(last), 32'(m_last));
        if (c == 0) begin
          fire = 1'b1; num = 12'(n); width = 4'(w); delay = 4'(d); expct = ex;
        end else begin
          fire = (c < done_c) ? 1'($urandom) : 1'b0;
          num = 12'($urandom); width = 4'($urandom); delay = 4'($urandom); expct = 1'($urandom);
        end
        rdy = rdy_t[c]; comp = cmp_t[c]; erst = ($urandom % 16 == 0);
        if (c == 0) m_cnt = 0;
        if (erst) m_err = 0;
        else if (es[c] && cmp_t[c] != ex && m_err != 65535) m_err++;
        if (es[c]) begin
          m_cnt++;
          m_last = cmp_t[c];
        end
        @(negedge clk);
      end
      fire = 1'b0; erst = 1'b0;
      repeat (2) @(negedge clk);
    end

    // Narrow instance: max pulse count with no gap, error counter saturation.
    s_fire = 1'b1; s_num = 4'hF; s_width = 4'd0; s_delay = 4'd0; s_expct = 1'b1; s_comp = 1'b0; s_rdy = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 47; c++) begin
      if (c == 43) chk("sat_errcnt_max_minus1", 32'(s_ecnt), 14);
      if (c == 46) chk("sat_done", 32'(s_done), 1);
      if (c == 47) begin
        chk("sat_pulse_cnt_max", 32'(s_pcnt), 15);
        chk("sat_errcnt_full", 32'(s_ecnt), 15);
      end
      s_fire = 1'b0;
      if (c < 47) @(negedge clk);
    end
    @(negedge clk);
    s_fire = 1'b1; s_num = 4'd3;
    @(negedge clk);
    s_fire = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      if (c == 4) chk("sat_hold_no_wrap", 32'(s_ecnt), 15);
      if (c == 10) chk("sat_done2", 32'(s_done), 1);
      if (c == 11) begin
        chk("sat_pulse_cnt2", 32'(s_pcnt), 3);
        chk("sat_errcnt_held", 32'(s_ecnt), 15);
      end
      if (c < 11) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
